// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: stalls, flushes, memory wait, halt
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        ex_memtoreg,
  input  logic [4:0]  ex_wbregnum,
  input  logic        ex_busy,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        mem_syscall_halt,
  input  logic        go,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_clr,
  output logic        idex_clr,
  output logic        exmem_clr,
  output logic        memwb_clr,
  output logic        exmem_bb,
  output logic        halted,
  output logic        mem_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {S_RUN, S_MEMWAIT, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;

  logic load_use;
  logic mem_wait;

  // Load in EX whose destination is a register the ID instruction actually reads
  assign load_use = ex_memtoreg && (ex_wbregnum != 5'd0) &&
                    ((id_use_rs && (id_rs == ex_wbregnum)) ||
                     (id_use_rt && (id_rt == ex_wbregnum)));

  // In MEMWAIT only mem_ready matters: the access is already outstanding
  assign mem_wait = ((state_q == S_RUN) && mem_req && !mem_ready) ||
                    ((state_q == S_MEMWAIT) && !mem_ready);

  // Stage controls by event priority, plus next-state for FSM and counters
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_clr   = 1'b0;
    idex_clr   = 1'b0;
    exmem_clr  = 1'b0;
    memwb_clr  = 1'b0;
    exmem_bb   = 1'b0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    stall_d    = stall_q;
    flush_d    = flush_q;

    if (state_q == S_HALT) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      if (go) state_d = S_RUN;
    end else if (mem_wait) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      stall_d = stall_q + 32'd1;
      if (wait_cnt_q == 8'd254) begin
        state_d    = S_HALT;
        timeout_d  = 1'b1;
        wait_cnt_d = 8'd0;
      end else begin
        state_d    = S_MEMWAIT;
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end else begin
      // RUN, or the MEMWAIT cycle in which memory completes
      state_d    = S_RUN;
      wait_cnt_d = 8'd0;
      if (mem_syscall_halt) begin
        {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
        state_d = S_HALT;
      end else if (ex_busy) begin
        {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
        exmem_bb = 1'b1;
        stall_d  = stall_q + 32'd1;
      end else if (ex_branch_taken) begin
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        ifid_clr = 1'b1;
        idex_clr = 1'b1;
        flush_d  = flush_q + 32'd1;
      end else if (load_use) begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        idex_clr = 1'b1;
        stall_d  = stall_q + 32'd1;
      end
    end

    // Reset holds every stage register cleared and frozen
    if (rst) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      {ifid_clr, idex_clr, exmem_clr, memwb_clr}    = 4'b1111;
      exmem_bb = 1'b0;
    end
  end

  // FSM state, wait counter, sticky timeout and event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RUN;
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
      stall_q    <= 32'd0;
      flush_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign halted      = (state_q == S_HALT);
  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_wbregnum = '0;
  logic        id_use_rs = 0, id_use_rt = 0, ex_memtoreg = 0, ex_busy = 0;
  logic        ex_branch_taken = 0, mem_req = 0, mem_ready = 0;
  logic        mem_syscall_halt = 0, go = 0;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_clr, idex_clr, exmem_clr, memwb_clr, exmem_bb;
  logic        halted, mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_memtoreg(ex_memtoreg), .ex_wbregnum(ex_wbregnum),
    .ex_busy(ex_busy), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .mem_syscall_halt(mem_syscall_halt), .go(go),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_clr(ifid_clr), .idex_clr(idex_clr), .exmem_clr(exmem_clr),
    .memwb_clr(memwb_clr), .exmem_bb(exmem_bb),
    .halted(halted), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Output patterns {pc,ifid,idex,exmem,memwb en, ifid,idex,exmem,memwb clr, bb}
  localparam logic [9:0] P_RUN    = 10'b11111_0000_0;
  localparam logic [9:0] P_FREEZE = 10'b00000_0000_0;
  localparam logic [9:0] P_RESET  = 10'b00000_1111_0;
  localparam logic [9:0] P_BUSY   = 10'b00001_0000_1;
  localparam logic [9:0] P_FLUSH  = 10'b10011_1100_0;
  localparam logic [9:0] P_LU     = 10'b00011_0100_0;
  localparam logic [9:0] P_SYSC   = 10'b00001_0000_0;

  localparam int M_RUN = 0, M_WAIT = 1, M_HALT = 2;

  function automatic bit lu_hazard();
    logic [4:0] src [2];
    bit         use_it [2];
    src[0] = id_rs; use_it[0] = id_use_rs;
    src[1] = id_rt; use_it[1] = id_use_rt;
    if (!ex_memtoreg || ex_wbregnum == 0) return 0;
    for (int k = 0; k < 2; k++)
      if (use_it[k] && src[k] == ex_wbregnum) return 1;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pick the winning event by priority, compare every cycle
  initial begin
    int m_mode = M_RUN, m_wait = 0, m_stall = 0, m_flush = 0;
    bit m_to = 0;
    int n_mode, n_wait, n_stall, n_flush;
    bit n_to;
    logic [9:0] exp;
    bit e_halt, e_to;
    int e_stall, e_flush;
    bit waiting;
    forever begin
      @(negedge clk);
      n_mode = m_mode; n_wait = m_wait; n_stall = m_stall; n_flush = m_flush; n_to = m_to;
      e_halt = (m_mode == M_HALT); e_to = m_to; e_stall = m_stall; e_flush = m_flush;
      if (rst) begin
        exp = P_RESET; e_halt = 0; e_to = 0; e_stall = 0; e_flush = 0;
        n_mode = M_RUN; n_wait = 0; n_stall = 0; n_flush = 0; n_to = 0;
      end else if (m_mode == M_HALT) begin
        exp = P_FREEZE;
        if (go) n_mode = M_RUN;
      end else begin
        waiting = (m_mode == M_RUN) ? (mem_req && !mem_ready) : !mem_ready;
        if (waiting) begin
          exp = P_FREEZE;
          n_stall = m_stall + 1;
          n_wait = m_wait + 1;
          if (n_wait == 255) begin n_mode = M_HALT; n_to = 1; n_wait = 0; end
          else n_mode = M_WAIT;
        end else begin
          n_mode = M_RUN; n_wait = 0;
          if (mem_syscall_halt) begin exp = P_SYSC; n_mode = M_HALT; end
          else if (ex_busy) begin exp = P_BUSY; n_stall = m_stall + 1; end
          else if (ex_branch_taken) begin exp = P_FLUSH; n_flush = m_flush + 1; end
          else if (lu_hazard()) begin exp = P_LU; n_stall = m_stall + 1; end
          else exp = P_RUN;
        end
      end
      chk("model_ctrl", {22'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                         ifid_clr, idex_clr, exmem_clr, memwb_clr, exmem_bb}, {22'd0, exp});
      chk("model_halted", {31'd0, halted}, {31'd0, e_halt});
      chk("model_timeout", {31'd0, mem_timeout}, {31'd0, e_to});
      chk("model_stall", stall_cnt, e_stall);
      chk("model_flush", flush_cnt, e_flush);
      @(posedge clk);
      m_mode = n_mode; m_wait = n_wait; m_stall = n_stall; m_flush = n_flush; m_to = n_to;
    end
  end

  task automatic step(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk); #1; endtask

  typedef struct { bit ld; logic [4:0] wb; bit urs; logic [4:0] rs; bit urt; logic [4:0] rt; bit hz; } lu_vec_t;
  lu_vec_t lu_tab [7] = '{
    '{1, 5'd5,  0, 5'd5,  1, 5'd5,  1},
    '{1, 5'd0,  1, 5'd0,  1, 5'd0,  0},
    '{1, 5'd7,  1, 5'd7,  0, 5'd0,  1},
    '{1, 5'd7,  0, 5'd7,  0, 5'd7,  0},
    '{0, 5'd7,  1, 5'd7,  1, 5'd7,  0},
    '{1, 5'd31, 1, 5'd31, 0, 5'd0,  1},
    '{1, 5'd9,  1, 5'd8,  1, 5'd10, 0}
  };

  // Directed stimulus with hand-computed literal expectations
  initial begin
    step(); step();
    mid();
    chk("rst_pc_en", pc_en, 0); chk("rst_ifid_clr", ifid_clr, 1); chk("rst_stall", stall_cnt, 0);
    step(); rst = 0;
    mid();
    chk("run_default", {pc_en, ifid_en, idex_en, exmem_en, memwb_en, idex_clr}, 6'b111110);

    // load-use on rt
    step(); ex_memtoreg = 1; ex_wbregnum = 5; id_use_rt = 1; id_rt = 5;
    mid();
    chk("lu_pc_en", pc_en, 0); chk("lu_ifid_en", ifid_en, 0); chk("lu_idex_clr", idex_clr, 1);
    chk("lu_stall_before", stall_cnt, 0);
    step(); ex_branch_taken = 1;
    chk("lu_stall_after", stall_cnt, 1);
    // same load-use with a taken branch: flush wins
    mid();
    chk("br_pc_en", pc_en, 1); chk("br_ifid_clr", ifid_clr, 1); chk("br_idex_clr", idex_clr, 1);
    step(); ex_branch_taken = 0; ex_memtoreg = 0; id_use_rt = 0;
    chk("br_flush", flush_cnt, 1); chk("br_stall", stall_cnt, 1);

    // three wait cycles then ready
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      mid(); chk("mw_frozen", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 0); step();
    end
    mem_ready = 1;
    mid(); chk("mw_ready_run", {pc_en, memwb_en}, 2'b11);
    step(); mem_req = 0; mem_ready = 0;
    chk("mw_stall", stall_cnt, 4);

    // busy with a pending branch: bubble, no flush
    ex_busy = 1; ex_branch_taken = 1;
    for (int i = 0; i < 2; i++) begin
      mid(); chk("busy_bb", exmem_bb, 1); chk("busy_memwb", memwb_en, 1); chk("busy_noflush", ifid_clr, 0);
      step();
    end
    ex_busy = 0;
    mid(); chk("busy_then_flush", ifid_clr, 1);
    step(); ex_branch_taken = 0;
    chk("busy_stall", stall_cnt, 6); chk("busy_flush", flush_cnt, 2);

    // load-use truth table
    foreach (lu_tab[i]) begin
      ex_memtoreg = lu_tab[i].ld; ex_wbregnum = lu_tab[i].wb;
      id_use_rs = lu_tab[i].urs; id_rs = lu_tab[i].rs;
      id_use_rt = lu_tab[i].urt; id_rt = lu_tab[i].rt;
      mid(); chk("lu_tab_pc_en", pc_en, !lu_tab[i].hz);
      step();
    end
    ex_memtoreg = 0; id_use_rs = 0; id_use_rt = 0;
    chk("lu_tab_stall", stall_cnt, 9);

    // syscall halt and resume
    mem_syscall_halt = 1;
    mid(); chk("sys_memwb", memwb_en, 1); chk("sys_pc_en", pc_en, 0);
    step(); mem_syscall_halt = 0;
    mid(); chk("sys_halted", halted, 1); chk("sys_en", {pc_en, memwb_en}, 0);
    step(); go = 1;
    mid(); chk("sys_go_cycle", pc_en, 0);
    step(); go = 0;
    mid(); chk("sys_resume", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b11111);
    step(); go = 1;
    mid(); chk("go_in_run", halted, 0);
    step(); go = 0;

    // reset mid-MEMWAIT
    mem_req = 1;
    step(); step();
    rst = 1;
    mid(); chk("rst_mw_clr", memwb_clr, 1); chk("rst_mw_stall", stall_cnt, 0);
    step(); rst = 0; mem_req = 0;
    mid(); chk("rst_mw_release", {pc_en, idex_clr}, 2'b10);
    step();

    // timeout after 255 wait cycles
    mem_req = 1; mem_ready = 0;
    for (int i = 1; i <= 260; i++) begin
      mid();
      if (i == 255) begin chk("to_not_yet", halted, 0); chk("to_frozen", pc_en, 0); end
      if (i == 256) begin
        chk("to_halted", halted, 1); chk("to_flag", mem_timeout, 1); chk("to_stall", stall_cnt, 255);
      end
      step();
    end
    mem_req = 0; go = 1;
    mid(); chk("to_halt_hold", halted, 1);
    step(); go = 0;
    mid(); chk("to_resume", pc_en, 1); chk("to_sticky", mem_timeout, 1); chk("to_run", halted, 0);

    // reset while halted clears the sticky flag
    step(); mem_syscall_halt = 1;
    step(); mem_syscall_halt = 0;
    mid(); chk("halt2", halted, 1);
    step(); rst = 1;
    mid(); chk("rst_halt_to", mem_timeout, 0); chk("rst_halt_h", halted, 0);
    step(); rst = 0;
    mid(); chk("rst_halt_release", pc_en, 1);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on posedge clk.
REQ-002 SHALL: rst  in  1  reset, asynchronous and active-high.
REQ-003 SHALL: id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-004 SHALL: id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt.
REQ-005 SHALL: ex_memtoreg  in  1  EX instruction is a load; ex_wbregnum  in  5  its destination.
REQ-006 SHALL: ex_busy  in  1  EX multi-cycle unit (mul/div) not finished; ex_branch_taken  in  1  EX resolved a taken branch/jump.
REQ-007 SHALL: mem_req  in  1  MEM stage accesses data memory; mem_ready  in  1  memory completes this cycle.
REQ-008 SHALL: mem_syscall_halt  in  1  halting SYSCALL present in MEM; go  in  1  resume pulse.
REQ-009 SHALL: pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables (EN input of each stage register).
REQ-010 SHALL: ifid_clr, idex_clr, exmem_clr, memwb_clr  out  1 each  synchronous clears (CLR of each stage register); exmem_bb  out  1  EX/MEM bubble insert (bb).
REQ-011 SHALL: halted  out  1; mem_timeout  out  1 sticky error; stall_cnt, flush_cnt  out  32 each  event counters.

Function
REQ-012 SHALL: FSM states RUN, MEMWAIT, HALT; stage-control outputs combinational from state and inputs; counters/state registered.
REQ-013 SHALL: RUN default (no event): all en=1, all clr=0, exmem_bb=0.
REQ-014 SHALL: priority, highest first: HALT state > memory wait > ex_busy > ex_branch_taken > load-use.
REQ-015 SHALL: memory wait = (RUN and mem_req and !mem_ready) or MEMWAIT state: all en=0, all clr=0, bb=0; RUN->MEMWAIT same edge.
REQ-016 SHALL: MEMWAIT->RUN on the edge where mem_ready=1; that cycle's outputs equal RUN outputs for the other inputs.
REQ-017 SHALL: 8-bit wait counter counts MEMWAIT cycles; on reaching 255 without mem_ready: set mem_timeout, go to HALT.
REQ-018 SHALL: ex_busy: pc_en=ifid_en=idex_en=exmem_en=0, exmem_bb=1, memwb_en=1 (bubble enters MEM, older instr drains).
REQ-019 SHALL: ex_branch_taken (no higher event): pc_en=1, ifid_clr=1, idex_clr=1, others en=1; flush_cnt+1.
REQ-020 SHALL: load-use = ex_memtoreg and ex_wbregnum!=0 and ((id_use_rs and id_rs==ex_wbregnum) or (id_use_rt and id_rt==ex_wbregnum)): pc_en=ifid_en=0, idex_clr=1, exmem_en=memwb_en=1.
REQ-021 SHALL: stall_cnt+1 every cycle any of memory wait, ex_busy, load-use is active; counters wrap at 2^32-1 -> 0.
REQ-022 SHALL: mem_syscall_halt in RUN, no memory wait: memwb_en=1, all other en=0, go to HALT next edge.
REQ-023 SHALL: HALT: all en=0, clr=0, bb=0, halted=1; go=1 -> RUN next edge; go ignored outside HALT; mem_timeout not cleared by go.
REQ-024 SHALL: never assert an en and its own clr together, nor exmem_bb with exmem_en or exmem_clr.

Reset
REQ-025 SHALL: while rst=1: state RUN, wait counter 0, stall_cnt=flush_cnt=0, mem_timeout=0, halted=0, all en=0, all clr=1, exmem_bb=0.
REQ-026 SHALL: rst asserted mid-MEMWAIT or HALT returns to RUN immediately; first cycle after release outputs RUN defaults.

Verification
REQ-027 SHALL: ex_memtoreg=1, ex_wbregnum=5, id_use_rt=1, id_rt=5 -> pc_en=0, ifid_en=0, idex_clr=1, stall_cnt 0->1.
REQ-028 SHALL: same load-use plus ex_branch_taken=1 -> pc_en=1, ifid_clr=1, idex_clr=1, flush_cnt 0->1, stall_cnt unchanged.
REQ-029 SHALL: mem_req=1, mem_ready=0 for 3 cycles then 1 -> all en=0 for 3 cycles, RUN on 4th, stall_cnt=3.
REQ-030 SHALL: mem_req=1, mem_ready=0 held 260 cycles -> mem_timeout=1, halted=1 after 255th wait cycle; go -> RUN, mem_timeout stays 1.
REQ-031 SHALL: ex_busy=1 2 cycles with ex_branch_taken=1 -> exmem_bb=1, memwb_en=1, no flush until ex_busy=0.
REQ-032 SHALL: mem_syscall_halt=1 -> memwb_en=1 one cycle, then halted=1 and all en=0; go pulse -> all en=1 next cycle.
